pixel_uart_tx: RTL and testbench

Output stage of the image pipeline. After the processing core signals that the processed frame is in the output buffer, this block reads one pixel at a time from the buffer's synchronous read port. It splits each pixel into BPP bytes and transmits them over a single UART line (8N1). It drives the top-level tx, tx_active and done outputs.

---
 rtl/pixel_uart_tx_if.sv | 13 +
 rtl/pixel_uart_tx.sv | 148 ++++++++++++++
 tb/tb_pixel_uart_tx.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_uart_tx_if.sv
// Synchronous read port of the output frame buffer: the transmitter strobes an address,
// and the buffer returns the pixel word on the following cycle.
interface pixel_uart_tx_if #(
  parameter int BPP    = 3,
  parameter int ADDR_W = 10
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [8*BPP-1:0]  rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/pixel_uart_tx.sv
// Streams a frame of BPP-byte pixels from the output buffer over a UART 8N1 line, MSB byte first.
// Per pixel: 2 fetch cycles then BPP back-to-back 10-bit characters; no backpressure, start is only taken in IDLE.
module pixel_uart_tx #(
  parameter int BPP           = 3,
  parameter int ADDR_W        = 10,
  parameter int TICK_PER_HALF = 1302
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_pix,
  pixel_uart_tx_if.master   rd_bus,
  output logic              tx,
  output logic              tx_active,
  output logic              done
);
  localparam int BIT_CLKS = 2 * TICK_PER_HALF;
  localparam int TW       = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int BIW      = (BPP > 1) ? $clog2(BPP) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(BIT_CLKS - 1);
  localparam logic [BIW-1:0] BYTE_LAST = BIW'(BPP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_START, S_DATA, S_STOP, S_FIN
  } state_t;

  state_t            r_state;
  logic [TW-1:0]     r_tick;
  logic [2:0]        r_bit_idx;
  logic [BIW-1:0]    r_byte_idx;
  logic [ADDR_W-1:0] r_pix_cnt;
  logic [ADDR_W-1:0] r_num_pix;
  logic [8*BPP-1:0]  r_pix;
  logic [6:0]        r_shift;
  logic              r_tx;
  logic              r_tx_active;
  logic              r_done;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;

  logic              w_bit_end;
  logic [TW-1:0]     w_tick_nxt;
  logic [7:0]        w_cur_byte;
  logic              w_last_pix;

  assign w_bit_end  = (r_tick == TICK_LAST);
  assign w_tick_nxt = w_bit_end ? '0 : r_tick + TW'(1);
  // The pixel register shifts left after each byte, so the current byte is always the top one.
  assign w_cur_byte = r_pix[8*BPP-1 -: 8];
  assign w_last_pix = ({1'b0, r_pix_cnt} + (ADDR_W+1)'(1)) >= {1'b0, r_num_pix};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_tick      <= '0;
      r_bit_idx   <= '0;
      r_byte_idx  <= '0;
      r_pix_cnt   <= '0;
      r_num_pix   <= '0;
      r_pix       <= '0;
      r_shift     <= '0;
      r_tx        <= 1'b1;
      r_tx_active <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
    end else begin
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (start) begin
            r_num_pix <= num_pix;
            r_pix_cnt <= '0;
            if (num_pix == '0) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_FETCH;
              r_tx_active <= 1'b1;
              r_rd_en     <= 1'b1;
              r_rd_addr   <= '0;
            end
          end
        end
        S_FETCH: r_state <= S_LATCH;
        S_LATCH: begin
          r_pix      <= rd_bus.rd_data;
          r_byte_idx <= '0;
          r_tick     <= '0;
          r_tx       <= 1'b0;
          r_state    <= S_START;
        end
        S_START: begin
          r_tick <= w_tick_nxt;
          if (w_bit_end) begin
            r_tx      <= w_cur_byte[0];
            r_shift   <= w_cur_byte[7:1];
            r_bit_idx <= '0;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          r_tick <= w_tick_nxt;
          if (w_bit_end) begin
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
        S_STOP: begin
          r_tick <= w_tick_nxt;
          if (w_bit_end) begin
            if (r_byte_idx != BYTE_LAST) begin
              r_byte_idx <= r_byte_idx + BIW'(1);
              r_pix      <= r_pix << 8;
              r_tx       <= 1'b0;
              r_state    <= S_START;
            end else if (!w_last_pix) begin
              r_pix_cnt <= r_pix_cnt + ADDR_W'(1);
              r_rd_en   <= 1'b1;
              r_rd_addr <= r_pix_cnt + ADDR_W'(1);
              r_state   <= S_FETCH;
            end else begin
              r_done      <= 1'b1;
              r_tx_active <= 1'b0;
              r_state     <= S_FIN;
            end
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_bus.rd_en   = r_rd_en;
  assign rd_bus.rd_addr = r_rd_addr;
  assign tx             = r_tx;
  assign tx_active      = r_tx_active;
  assign done           = r_done;
endmodule

// File: tb/tb_pixel_uart_tx.sv
// Bench for pixel_uart_tx: fast-baud instance for frame/protocol vectors, default-baud single-byte instance for timing.
module tb_pixel_uart_tx;
  localparam int BPP    = 3;
  localparam int ADDR_W = 10;
  localparam int TPH    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, s_start;
  logic [ADDR_W-1:0] num_pix, s_num_pix;
  logic              tx, tx_active, done;
  logic              s_tx, s_tx_active, s_done;

  pixel_uart_tx_if #(.BPP(BPP), .ADDR_W(ADDR_W)) bus ();
  pixel_uart_tx_if #(.BPP(1),   .ADDR_W(ADDR_W)) s_bus ();

  pixel_uart_tx #(.BPP(BPP), .ADDR_W(ADDR_W), .TICK_PER_HALF(TPH)) dut (
    .clk(clk), .rst(rst), .start(start), .num_pix(num_pix), .rd_bus(bus),
    .tx(tx), .tx_active(tx_active), .done(done));

  pixel_uart_tx #(.BPP(1), .ADDR_W(ADDR_W)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .num_pix(s_num_pix), .rd_bus(s_bus),
    .tx(s_tx), .tx_active(s_tx_active), .done(s_done));

  // Buffer models: data is only meaningful the cycle after rd_en, junk otherwise.
  logic [23:0] mem [0:7];
  always @(posedge clk) bus.rd_data <= bus.rd_en ? mem[bus.rd_addr[2:0]] : 24'hDEAD5A;
  always @(posedge clk) s_bus.rd_data <= s_bus.rd_en ? 8'h55 : 8'hFF;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [7:0] exp_q [$];

  task automatic push_pixel(input logic [23:0] p);
    for (int b = 0; b < BPP; b++) exp_q.push_back(p[8*(BPP-1-b) +: 8]);
  endtask

  // UART receiver: samples mid-bit, compares each 10-bit character against the scoreboard.
  logic       mon_on = 1'b0;
  logic       mon_abort = 1'b0;
  logic [7:0] m_d;
  logic       m_sb, m_sp;
  always begin : uart_mon
    @(negedge clk);
    if (mon_on && tx == 1'b0) begin
      repeat (TPH) @(negedge clk);
      m_sb = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (2*TPH) @(negedge clk);
        m_d[i] = tx;
      end
      repeat (2*TPH) @(negedge clk);
      m_sp = tx;
      if (!mon_abort) begin
        if (exp_q.size() == 0)
          check("rx_extra_byte", exp_q.size(), 1);
        else
          check("rx_char", {m_sp, m_d, m_sb}, {1'b1, exp_q.pop_front(), 1'b0});
      end
    end
  end

  // Drive one frame from a negedge and watch it cycle by cycle; done must appear exactly at exp_done.
  task automatic run_frame(input string tag, input int npix, input int exp_done, input int restart_k);
    int k, rd_cnt, addr_bad, done_cnt, done_at, act_bad, idle_low;
    rd_cnt = 0; addr_bad = 0; done_cnt = 0; done_at = -1; act_bad = 0; idle_low = 0;
    num_pix = ADDR_W'(npix);
    start   = 1'b1;
    k = 0;
    while (k < exp_done + 8) begin
      @(negedge clk);
      k++;
      start = (k == restart_k);
      if (bus.rd_en) begin
        if (bus.rd_addr != ADDR_W'(rd_cnt)) addr_bad++;
        rd_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (tx_active != (npix > 0 && k < exp_done)) act_bad++;
      if (!tx_active && !tx) idle_low++;
    end
    start = 1'b0;
    check({tag, ".done_cycle"}, done_at, exp_done);
    check({tag, ".done_pulses"}, done_cnt, 1);
    check({tag, ".rd_en_count"}, rd_cnt, npix);
    check({tag, ".rd_addr_seq_bad"}, addr_bad, 0);
    check({tag, ".tx_active_bad"}, act_bad, 0);
    check({tag, ".tx_low_while_idle"}, idle_low, 0);
    check({tag, ".bytes_left"}, exp_q.size(), 0);
  endtask

  typedef struct packed {
    logic [15:0]       npix;
    logic [2:0][23:0]  pix;
    logic [15:0]       exp_done;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [23:0] p0, input logic [23:0] p1,
                              input logic [23:0] p2, input int e);
    vec_t v;
    v.npix = 16'(n); v.pix[0] = p0; v.pix[1] = p1; v.pix[2] = p2; v.exp_done = 16'(e);
    return v;
  endfunction

  vec_t vecs [4];

  initial begin
    int t, t_start, t_last, t_done, n_edges, iv_min, iv_max, first_iv;
    logic prev;

    // done cycle = 1 + npix*(2 + 3*20*2), counted in negedges after start is raised
    vecs[0] = mk(1, 24'hA53C0F, 24'h000000, 24'h000000, 123);
    vecs[1] = mk(3, 24'h000000, 24'hFFFFFF, 24'h123456, 367);
    vecs[2] = mk(0, 24'h111111, 24'h222222, 24'h333333, 1);
    vecs[3] = mk(2, 24'h5A5A5A, 24'hC3E781, 24'h000000, 245);

    rst = 1'b0; start = 1'b0; s_start = 1'b0; num_pix = '0; s_num_pix = '0;
    for (int i = 0; i < 8; i++) mem[i] = 24'(i) * 24'h010101;
    repeat (3) @(negedge clk);
    check("reset.tx", tx, 1);
    check("reset.tx_active", tx_active, 0);
    check("reset.done", done, 0);
    check("reset.rd_en", bus.rd_en, 0);
    check("reset.rd_addr", bus.rd_addr, 0);
    rst = 1'b1;
    mon_on = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      for (int p = 0; p < 3; p++) mem[p] = vecs[v].pix[p];
      for (int p = 0; p < int'(vecs[v].npix); p++) push_pixel(vecs[v].pix[p]);
      run_frame($sformatf("vec%0d", v), int'(vecs[v].npix), int'(vecs[v].exp_done), -1);
      repeat (5) @(negedge clk);
    end

    // Second start during DATA of byte 0 must change nothing.
    mem[0] = 24'hA53C0F;
    push_pixel(24'hA53C0F);
    run_frame("restart_ignored", 1, 123, 20);
    repeat (5) @(negedge clk);

    // start held high with num_pix=0: FIN, IDLE, FIN again.
    num_pix = '0;
    start   = 1'b1;
    @(negedge clk); check("held.done_k1", done, 1);
    @(negedge clk); check("held.done_k2", done, 0);
    @(negedge clk); check("held.done_k3", done, 1);
    check("held.tx_active", tx_active, 0);
    start = 1'b0;
    repeat (5) @(negedge clk);

    // Reset in DATA of pixel 1, byte 0; pixel 0 bytes are received before that.
    mem[0] = 24'hA53C0F; mem[1] = 24'h5A5A5A; mem[2] = 24'hC3E781;
    push_pixel(mem[0]); push_pixel(mem[1]); push_pixel(mem[2]);
    num_pix = ADDR_W'(3);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (149) @(negedge clk);
    check("pre_reset.rd_addr", bus.rd_addr, 1);
    mon_abort = 1'b1;
    rst       = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid_reset.tx", tx, 1);
    check("mid_reset.tx_active", tx_active, 0);
    check("mid_reset.rd_addr", bus.rd_addr, 0);
    check("mid_reset.rd_en", bus.rd_en, 0);
    check("mid_reset.done", done, 0);
    repeat (60) @(negedge clk);
    check("mid_reset.no_done", done, 0);
    exp_q.delete();
    mon_abort = 1'b0;
    push_pixel(mem[0]); push_pixel(mem[1]);
    run_frame("after_reset", 2, 245, -1);
    repeat (5) @(negedge clk);

    // Default baud: byte 0x55 toggles every bit, so all edge spacings equal one bit period.
    s_num_pix = ADDR_W'(1);
    s_start   = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    prev = s_tx; t_start = -1; t_last = -1; t_done = -1; n_edges = 0;
    iv_min = 1 << 30; iv_max = 0; first_iv = -1;
    for (t = 1; t < 30000 && t_done < 0; t++) begin
      @(negedge clk);
      if (s_tx != prev) begin
        if (t_start < 0) t_start = t;
        else begin
          if (first_iv < 0) first_iv = t - t_last;
          if (t - t_last < iv_min) iv_min = t - t_last;
          if (t - t_last > iv_max) iv_max = t - t_last;
          n_edges++;
        end
        t_last = t;
      end
      if (s_done) t_done = t;
      prev = s_tx;
    end
    check("slow.done_seen", (t_done >= 0), 1);
    check("slow.bit_period", first_iv, 2604);
    check("slow.bit_min", iv_min, 2604);
    check("slow.bit_max", iv_max, 2604);
    check("slow.edges", n_edges, 9);
    check("slow.byte_frame", t_done - t_start, 26040);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
